// File: rtl/wrap_logger_pkg.sv
// Shared types and constants for the counter wrap event logger.
// Holds the event record layout and the drop-counter ceiling.
package wrap_logger_pkg;

  localparam int LOG_CNT_W = 4;
  localparam int LOG_TS_W  = 16;
  localparam int LOG_IDX_W = 8;
  localparam int LOG_DEPTH = 8;
  localparam int EV_W      = 1 + LOG_IDX_W + LOG_TS_W;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef struct packed {
    logic                 err;
    logic [LOG_IDX_W-1:0] wrap_idx;
    logic [LOG_TS_W-1:0]  ts;
  } event_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO, async active-high reset.
// Ports: clr flush, wr_en/wr_data/full, rd_en/rd_data/empty, level.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and
  // empty are distinguishable at equal slot index.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    level   = wr_ptr_q - rd_ptr_q;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd   = rd_en & ~empty;
    // A pop on the same edge frees the slot a full
    // FIFO would otherwise refuse.
    do_wr   = wr_en & (~full | do_rd);
    rd_data = mem_q[rd_ptr_q[AW-1:0]];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reads are masked by
  // empty at the consumer.
  always_ff @(posedge clk) begin
    if (do_wr && !clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/wrap_event_logger.sv
// Timestamps counter wrap pulses and queues them for stream readout.
// Ports: clear, overflow_in/count_in in; ev_* stream, fifo_level, dropped_cnt out.
module wrap_event_logger
  import wrap_logger_pkg::*;
#(
  parameter int CNT_W = LOG_CNT_W,
  parameter int TS_W  = LOG_TS_W,
  parameter int IDX_W = LOG_IDX_W,
  parameter int DEPTH = LOG_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      overflow_in,
  input  logic [CNT_W-1:0]          count_in,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [IDX_W+TS_W:0]       ev_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [7:0]                dropped_cnt
);

  localparam int DW = 1 + IDX_W + TS_W;

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  ts_d;
  logic [IDX_W-1:0] wrap_idx_q;
  logic [IDX_W-1:0] wrap_idx_d;
  logic [7:0]       drop_q;
  logic [7:0]       drop_d;

  logic             push;
  logic             pop;
  logic             drop;
  logic             err;
  logic             full;
  logic             empty;
  logic [DW-1:0]    ev_in;
  logic [DW-1:0]    rd_data;

  always_comb begin
    // clear wins over a same-cycle wrap and pop.
    push  = overflow_in & ~clear;
    pop   = ~empty & ev_ready & ~clear;
    err   = (count_in != '0);
    ev_in = {err, wrap_idx_q, ts_q};
    drop  = push & full & ~pop;

    ts_d       = ts_q + TS_W'(1);
    wrap_idx_d = wrap_idx_q;
    drop_d     = drop_q;

    if (clear) begin
      ts_d       = '0;
      wrap_idx_d = '0;
      drop_d     = '0;
    end else begin
      // Index advances even for dropped events so
      // gaps reveal losses downstream.
      if (push) wrap_idx_d = wrap_idx_q + IDX_W'(1);
      if (drop && drop_q != DROP_MAX) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      wrap_idx_q <= '0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      wrap_idx_q <= wrap_idx_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clear),
    .wr_en   (push),
    .wr_data (ev_in),
    .full    (full),
    .rd_en   (pop),
    .rd_data (rd_data),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    ev_valid    = ~empty;
    ev_data     = empty ? '0 : rd_data;
    dropped_cnt = drop_q;
  end

endmodule
